// File: rtl/nand_pkg.sv
// ---------------------------------------------------------------------------
// nand_pkg
// Shared types and constants for the NAND byte-stream engine.
//   state_t    : operand capture phase (S_A waits for A, S_B waits for B)
//   WIDTH_DEF  : default operand/result width
//   DEPTH_DEF  : default result FIFO depth
//   nand_op    : bitwise NAND on up to MAX_WIDTH bits; callers truncate
// ---------------------------------------------------------------------------
package nand_pkg;

    typedef enum logic {
        S_A = 1'b0,
        S_B = 1'b1
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int MAX_WIDTH = 64;

    // Written wide so any WIDTH up to MAX_WIDTH can share one function.
    function automatic logic [MAX_WIDTH-1:0] nand_op(input logic [MAX_WIDTH-1:0] a,
                                                     input logic [MAX_WIDTH-1:0] b);
        return ~(a & b);
    endfunction

endpackage

// File: rtl/nand_fifo.sv
// ---------------------------------------------------------------------------
// nand_fifo
// Synchronous first-word-fall-through FIFO for NAND results.
//   clk, rst   : clock, synchronous active-high reset (clears storage too)
//   push       : write push_data at the tail (ignored when full)
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   pop_data   : head entry, read combinationally from storage
//   full/empty : derived from the occupancy counter
//   level      : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module nand_fifo
    import nand_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Storage and pointers. Pointers are exactly AW bits wide so they wrap
    // on their own because DEPTH is a power of two; occupancy is tracked
    // separately so full and empty never need pointer comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/nand_stream_core.sv
// ---------------------------------------------------------------------------
// nand_stream_core
// Captures operand pairs (A then B) over a valid/ready handshake, computes
// ~(A & B) and queues results in a FWFT FIFO drained by a second handshake.
//   clk, rst    : clock, synchronous active-high reset (priority over ena)
//   ena         : design selected; while low everything is frozen
//   in_data     : operand byte
//   in_valid    : operand valid
//   in_ready    : operand accepted when in_valid is also high
//   out_data    : FIFO head result
//   out_valid   : FIFO non-empty (and ena high)
//   out_ready   : consumer pops the head
//   fifo_level  : FIFO occupancy
//   op_count    : results produced, modulo 256
// ---------------------------------------------------------------------------
module nand_stream_core
    import nand_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               op_count
);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] result;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    // Handshake outputs use registered flags only, so neither in_valid nor
    // out_ready can reach an output combinationally. A pop in the same cycle
    // therefore cannot unblock a stalled B.
    assign in_ready  = ena && ((state == S_A) || !fifo_full);
    assign out_valid = ena && !fifo_empty;
    assign push      = ena && (state == S_B) && in_valid && !fifo_full;
    assign pop       = ena && !fifo_empty && out_ready;
    assign result    = WIDTH'(nand_op(MAX_WIDTH'(a_reg), MAX_WIDTH'(in_data)));

    // Operand-phase FSM with the captured A and the result counter.
    // Reset is checked before ena so a captured A is always discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_A;
            a_reg    <= '0;
            op_count <= '0;
        end else if (ena) begin
            case (state)
                S_A: begin
                    if (in_valid) begin
                        a_reg <= in_data;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (push) begin
                        op_count <= op_count + 8'd1;
                        state    <= S_A;
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

    nand_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (result),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_nand_stream_core.sv
// ---------------------------------------------------------------------------
// tb_nand_stream_core
// Self-checking bench for nand_stream_core. A queue-based reference model
// predicts handshake outputs, occupancy, counter and head data each cycle.
// ---------------------------------------------------------------------------
module tb_nand_stream_core;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ena;
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [7:0]             op_count;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: results still queued, whether an A is held, and
    // the number of results produced.
    logic [7:0] mq[$];
    bit         haveA   = 1'b0;
    logic [7:0] aModel  = 8'h00;
    int         opModel = 0;

    bit         acc;

    always #5 clk = ~clk;

    nand_stream_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .op_count   (op_count)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assertCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Compare every DUT output against what the model predicts now.
    task automatic checkOutput();
        checkVal("in_ready",   32'(in_ready),   32'(ena && (!haveA || mq.size() < DEPTH)));
        checkVal("out_valid",  32'(out_valid),  32'(ena && mq.size() > 0));
        checkVal("fifo_level", 32'(fifo_level), 32'(mq.size()));
        checkVal("op_count",   32'(op_count),   32'(opModel));
        if (mq.size() > 0) begin
            checkVal("out_data", 32'(out_data), 32'(mq[0]));
        end
    endtask

    // One clock of stimulus: drive inputs, predict, clock, update model, check.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic ordy,
                                 input logic en, input logic r, output bit accepted);
        bit expReady;
        bit doPush;
        bit doPop;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        ena       = en;
        rst       = r;
        expReady  = en && (!haveA || mq.size() < DEPTH);
        doPop     = en && (mq.size() > 0) && ordy;
        doPush    = en && haveA && v && (mq.size() < DEPTH);
        accepted  = !r && v && expReady;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            haveA   = 1'b0;
            aModel  = 8'h00;
            opModel = 0;
        end else begin
            if (doPop) begin
                void'(mq.pop_front());
            end
            if (doPush) begin
                mq.push_back(~(aModel & d));
                opModel = (opModel + 1) % 256;
                haveA   = 1'b0;
            end else if (en && v && !haveA) begin
                aModel = d;
                haveA  = 1'b1;
            end
        end
        checkOutput();
    endtask

    // Offer one byte until accepted; mode 0/1 fixes out_ready, 2 randomises it.
    task automatic sendByte(input logic [7:0] d, input int mode);
        bit   got;
        logic ordy;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            ordy = (mode == 2) ? logic'($urandom_range(0, 1)) : logic'(mode);
            applyStimulus(1'b1, d, ordy, 1'b1, 1'b0, got);
        end
        if (!got) begin
            failCount++;
            $display("[TB] FAIL send_timeout: observed no acceptance, required acceptance of %0h", d);
        end
    endtask

    task automatic idle(input logic ordy, input int n);
        bit dummy;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, ordy, 1'b1, 1'b0, dummy);
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);
        checkVal("rst_out_data",  32'(out_data),   32'h00);
        checkVal("rst_in_ready",  32'(in_ready),   32'h1);
        checkVal("rst_out_valid", 32'(out_valid),  32'h0);
        checkVal("rst_level",     32'(fifo_level), 32'h0);

        // Basic NAND
        $display("[TB] basic nand");
        sendByte(8'hF0, 0);
        sendByte(8'h3C, 0);
        checkVal("basic1_valid", 32'(out_valid), 32'h1);
        checkVal("basic1_data",  32'(out_data),  32'hCF);
        idle(1'b1, 1);
        sendByte(8'hFF, 0);
        sendByte(8'hFF, 0);
        checkVal("basic2_valid", 32'(out_valid), 32'h1);
        checkVal("basic2_data",  32'(out_data),  32'h00);
        idle(1'b1, 1);
        checkVal("basic_opcount", 32'(op_count), 32'd2);

        // Fill and stall
        $display("[TB] fill and stall");
        for (int i = 0; i < 4; i++) begin
            sendByte(8'($urandom), 0);
            sendByte(8'($urandom), 0);
        end
        checkVal("fill_level", 32'(fifo_level), 32'd4);
        sendByte(8'h5A, 0);
        checkVal("stall_in_ready", 32'(in_ready), 32'h0);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, acc);
        checkVal("stall_no_accept", 32'(acc), 32'h0);
        applyStimulus(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, acc);
        checkVal("pop_no_unblock", 32'(acc), 32'h0);
        checkVal("unstall_ready",  32'(in_ready), 32'h1);
        checkVal("unstall_level",  32'(fifo_level), 32'd3);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, acc);
        checkVal("stall_b_accept", 32'(acc), 32'h1);
        checkVal("refill_level",   32'(fifo_level), 32'd4);
        idle(1'b1, 4);

        // Simultaneous push and pop at level 1
        $display("[TB] simultaneous push/pop");
        sendByte(8'($urandom), 0);
        sendByte(8'($urandom), 0);
        for (int i = 0; i < 4; i++) begin
            sendByte(8'($urandom), 0);
            sendByte(8'($urandom), 1);
            checkVal("pushpop_level", 32'(fifo_level), 32'd1);
        end
        idle(1'b1, 2);

        // Reset mid-pair
        $display("[TB] reset mid-pair");
        sendByte(8'h0F, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);
        sendByte(8'hAA, 0);
        sendByte(8'h55, 0);
        checkVal("midrst_data",    32'(out_data),   32'hFF);
        checkVal("midrst_opcount", 32'(op_count),   32'd1);
        checkVal("midrst_level",   32'(fifo_level), 32'd1);
        idle(1'b1, 1);
        checkVal("midrst_empty",   32'(out_valid),  32'h0);

        // ena gating
        $display("[TB] ena gating");
        for (int i = 0; i < 2; i++) begin
            sendByte(8'($urandom), 0);
            sendByte(8'($urandom), 0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, acc);
        end
        checkVal("ena_in_ready",  32'(in_ready),   32'h0);
        checkVal("ena_out_valid", 32'(out_valid),  32'h0);
        checkVal("ena_level",     32'(fifo_level), 32'd2);
        idle(1'b1, 3);
        checkVal("ena_drained",   32'(fifo_level), 32'd0);

        // Counter wrap with random operands and random back-pressure
        $display("[TB] counter wrap");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 257; i++) begin
            sendByte(8'($urandom), 2);
            sendByte(8'($urandom), 2);
        end
        idle(1'b1, DEPTH + 1);
        checkVal("wrap_opcount", 32'(op_count),   32'd1);
        checkVal("wrap_empty",   32'(fifo_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/nand_stream_core.md
# nand_stream_core

Byte-stream NAND engine behind the `tt_um_Murra232_nand` pin wrapper. It captures operand pairs (A, then B) from the dedicated inputs with a valid/ready handshake and computes `~(A & B)`. Results are queued in a small first-word-fall-through FIFO and presented on the dedicated outputs with their own valid/ready handshake. The wrapper maps pins to ports and derives `rst` from `rst_n`. The cocotb bench in `test/` drives it through the wrapper.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width in bits.
- `DEPTH`, 4: result FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `rst`  in  1: reset, synchronous, active-high. The wrapper drives it as `~rst_n`.
- `ena`  in  1: design selected. While low, state, FIFO and counters are frozen.
- `in_data`  in  WIDTH: operand byte, from `ui_in`.
- `in_valid`  in  1: operand valid, from `uio_in[0]`.
- `in_ready`  out  1: operand accepted this cycle if `in_valid` is also high.
- `out_data`  out  WIDTH: FIFO head result, to `uo_out`.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: consumer pops the head, from `uio_in[1]`.
- `fifo_level`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `op_count`  out  8: number of results produced, modulo 256.

## Operation
- The FSM has two states, `S_A` and `S_B`.
- **`S_A`**: `in_ready`=1. On `in_valid` the byte is latched into `a_reg` and the FSM moves to `S_B`.
- **`S_B`**: `in_ready` = !full.
  - On `in_valid && in_ready`, `~(a_reg & in_data)` is pushed, `op_count` increments and the FSM returns to `S_A`.
  - When the FIFO is full, B is stalled with no push and no loss. A pop in the same cycle does not unblock it; `in_ready` is computed from the registered full flag only.
- **Pop**: a pop occurs when `out_valid && out_ready`. `out_data` is the head entry, combinationally from storage, and is don't-care when empty.
- **Push and pop in the same cycle**: both occur and `fifo_level` is unchanged. A push into an empty FIFO with `out_ready` high is not forwarded; it becomes visible the next cycle.
- **Pointers**: $clog2(DEPTH)-bit pointers wrap naturally. Full/empty are derived from `fifo_level`.
- **`op_count`**: wraps 255 -> 0 and is not affected by pops.
- **`ena` low**:
  - `in_ready`=0 and `out_valid`=0.
  - No state, pointer or counter changes.
  - `out_data` holds its value.
- **`rst`**: has priority over `ena`. It discards a captured A, empties the FIFO and clears the counter.

## Timing
- **Reset values**, outputs valid in the cycle after `rst` is sampled high:
  - FSM state = `S_A`, `a_reg`=0.
  - `in_ready`=1, provided `ena`=1.
  - `out_valid`=0, `out_data`=0 (storage cleared), `fifo_level`=0, `op_count`=0.
- **Latency**: B is accepted at edge N; the result appears with `out_valid`=1 after edge N. That is 1 cycle from B acceptance, 2 transfers per result.
- **Throughput**: one result every 2 cycles with continuous `in_valid` and `out_ready`.
- **Reset mid-operation**: if A was accepted and `rst` is asserted, the next accepted byte after reset is treated as A.
- **Outputs**:
  - `in_ready`, `out_valid` and `fifo_level` depend only on registers and `ena`.
  - There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Package `nand_pkg` holds:
  - the `state_t` enum {`S_A`, `S_B`};
  - the `WIDTH_DEF`=8 and `DEPTH_DEF`=4 constants;
  - the `nand_op` function.
- One sub-module, `nand_fifo`: parameterised synchronous FWFT FIFO with push, pop, full, empty and level outputs, and synchronous active-high reset. The FSM, `a_reg` and `op_count` live in `nand_stream_core`.

## Test plan
- **Basic NAND**: reset, then pairs A=0xF0,B=0x3C -> `out_data`=0xCF, and A=0xFF,B=0xFF -> 0x00, each with `out_valid` 1 cycle after B. `op_count`=2.
- **Fill/stall**: `out_ready`=0, send 4 pairs -> `fifo_level`=4. A fifth A is accepted; then `in_ready`=0 in `S_B`. Raise `out_ready` for 1 cycle -> `in_ready` returns 1 the next cycle, B is accepted, and the level is 4.
- **Simultaneous push/pop**: with level=1, a B acceptance and a pop in the same cycle -> level stays 1 and the correct order is preserved, checked against a scoreboard over 4 pairs.
- **Reset mid-pair**: accept A=0x0F, assert `rst` 1 cycle, then send 0xAA,0x55 -> result 0xFF. `op_count`=1 and no stale entry appears.
- **`ena` gating**: drop `ena` with level=2 and `in_valid`/`out_ready` high for 5 cycles -> `in_ready`=0, `out_valid`=0, level stays 2. Restore `ena` -> both entries drain in order.
- **Counter wrap**: 257 pairs with random operands -> `op_count`=1 and every result matches `~(A&B)`.
